// File: rtl/ccd_readout_sequencer.sv
// CCD frame readout sequencer: vertical row transfer, horizontal pixel shift and
// a one-cycle sample strobe per pixel, with frame-completion pulse.
module ccd_readout_sequencer #(
    parameter int unsigned V_PHASE_CYCLES = 4,
    parameter int unsigned H_PHASE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] width,
    input  logic [15:0] height,
    input  logic [3:0]  num_vertical_phases,
    input  logic [2:0]  num_horizontal_phases,
    input  logic        start_read,
    input  logic        abort,
    output logic [15:0] vertical_phases,
    output logic [7:0]  horizontal_phases,
    output logic        read_sample,
    output logic [15:0] pixel_x,
    output logic [15:0] pixel_y,
    output logic        busy,
    output logic        read_completed
);

    typedef enum logic [2:0] {S_IDLE, S_VSHIFT, S_HSHIFT, S_SAMPLE, S_DONE} state_t;

    localparam logic [15:0] V_LAST = 16'(V_PHASE_CYCLES - 1);
    localparam logic [15:0] H_LAST = 16'(H_PHASE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] width_q, width_d, height_q, height_d;
    logic [3:0]  nv_q, nv_d, vphase_q, vphase_d;
    logic [2:0]  nh_q, nh_d, hphase_q, hphase_d;
    logic [15:0] dwell_q, dwell_d, col_q, col_d, row_q, row_d;

    logic [15:0] vertical_phases_q, vertical_phases_d;
    logic [7:0]  horizontal_phases_q, horizontal_phases_d;
    logic        read_sample_q, read_sample_d;
    logic [15:0] pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
    logic        busy_q, busy_d;
    logic        read_completed_q, read_completed_d;

    always_comb begin
        state_d  = state_q;
        width_d  = width_q;
        height_d = height_q;
        nv_d     = nv_q;
        nh_d     = nh_q;
        vphase_d = vphase_q;
        hphase_d = hphase_q;
        dwell_d  = dwell_q;
        col_d    = col_q;
        row_d    = row_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_read) begin
                    width_d  = width;
                    height_d = height;
                    nv_d     = (num_vertical_phases == 4'd0) ? 4'd1 : num_vertical_phases;
                    nh_d     = (num_horizontal_phases == 3'd0) ? 3'd1 : num_horizontal_phases;
                    vphase_d = '0;
                    hphase_d = '0;
                    dwell_d  = '0;
                    col_d    = '0;
                    row_d    = '0;
                    state_d  = (width == 16'd0 || height == 16'd0) ? S_DONE : S_VSHIFT;
                end
            end
            S_VSHIFT: begin
                if (dwell_q == V_LAST) begin
                    dwell_d = '0;
                    if (vphase_q == nv_q - 4'd1) begin
                        vphase_d = '0;
                        hphase_d = '0;
                        col_d    = '0;
                        state_d  = S_HSHIFT;
                    end else begin
                        vphase_d = vphase_q + 4'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 16'd1;
                end
            end
            S_HSHIFT: begin
                if (dwell_q == H_LAST) begin
                    dwell_d = '0;
                    if (hphase_q == nh_q - 3'd1) begin
                        hphase_d = '0;
                        state_d  = S_SAMPLE;
                    end else begin
                        hphase_d = hphase_q + 3'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 16'd1;
                end
            end
            S_SAMPLE: begin
                // width/height are at least 1 here, so the -1 never wraps.
                if (col_q < width_q - 16'd1) begin
                    col_d    = col_q + 16'd1;
                    hphase_d = '0;
                    state_d  = S_HSHIFT;
                end else if (row_q < height_q - 16'd1) begin
                    row_d    = row_q + 16'd1;
                    col_d    = '0;
                    vphase_d = '0;
                    state_d  = S_VSHIFT;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            vphase_d = '0;
            hphase_d = '0;
            dwell_d  = '0;
            col_d    = '0;
            row_d    = '0;
        end

        // Outputs are registered from the next state so they align with it.
        vertical_phases_d   = (state_d == S_VSHIFT) ? (16'd1 << vphase_d) : '0;
        horizontal_phases_d = (state_d == S_HSHIFT) ? (8'd1 << hphase_d) : '0;
        read_sample_d       = (state_d == S_SAMPLE);
        read_completed_d    = (state_d == S_DONE);
        busy_d              = (state_d != S_IDLE);
        pixel_x_d           = (state_d == S_SAMPLE) ? col_d : pixel_x_q;
        pixel_y_d           = (state_d == S_SAMPLE) ? row_d : pixel_y_q;
        if (abort && state_q != S_IDLE) begin
            pixel_x_d = '0;
            pixel_y_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= S_IDLE;
            width_q             <= '0;
            height_q            <= '0;
            nv_q                <= '0;
            nh_q                <= '0;
            vphase_q            <= '0;
            hphase_q            <= '0;
            dwell_q             <= '0;
            col_q               <= '0;
            row_q               <= '0;
            vertical_phases_q   <= '0;
            horizontal_phases_q <= '0;
            read_sample_q       <= 1'b0;
            pixel_x_q           <= '0;
            pixel_y_q           <= '0;
            busy_q              <= 1'b0;
            read_completed_q    <= 1'b0;
        end else begin
            state_q             <= state_d;
            width_q             <= width_d;
            height_q            <= height_d;
            nv_q                <= nv_d;
            nh_q                <= nh_d;
            vphase_q            <= vphase_d;
            hphase_q            <= hphase_d;
            dwell_q             <= dwell_d;
            col_q               <= col_d;
            row_q               <= row_d;
            vertical_phases_q   <= vertical_phases_d;
            horizontal_phases_q <= horizontal_phases_d;
            read_sample_q       <= read_sample_d;
            pixel_x_q           <= pixel_x_d;
            pixel_y_q           <= pixel_y_d;
            busy_q              <= busy_d;
            read_completed_q    <= read_completed_d;
        end
    end

    assign vertical_phases   = vertical_phases_q;
    assign horizontal_phases = horizontal_phases_q;
    assign read_sample       = read_sample_q;
    assign pixel_x           = pixel_x_q;
    assign pixel_y           = pixel_y_q;
    assign busy              = busy_q;
    assign read_completed    = read_completed_q;

endmodule

// File: tb/tb_ccd_readout_sequencer.sv
// Scoreboard bench: two instances (V=2,H=1 and V=4,H=2) share stimulus; expected
// sample/completion events are queued per instance and popped by a monitor.
module tb_ccd_readout_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] width, height;
    logic [3:0]  num_vertical_phases;
    logic [2:0]  num_horizontal_phases;
    logic        start_read, abort;

    logic [15:0] a_v, b_v, a_x, a_y, b_x, b_y;
    logic [7:0]  a_h, b_h;
    logic        a_rs, a_busy, a_rc, b_rs, b_busy, b_rc;

    ccd_readout_sequencer #(.V_PHASE_CYCLES(2), .H_PHASE_CYCLES(1)) u_dut_a (
        .clk(clk), .rst(rst), .width(width), .height(height),
        .num_vertical_phases(num_vertical_phases), .num_horizontal_phases(num_horizontal_phases),
        .start_read(start_read), .abort(abort),
        .vertical_phases(a_v), .horizontal_phases(a_h), .read_sample(a_rs),
        .pixel_x(a_x), .pixel_y(a_y), .busy(a_busy), .read_completed(a_rc));

    ccd_readout_sequencer #(.V_PHASE_CYCLES(4), .H_PHASE_CYCLES(2)) u_dut_b (
        .clk(clk), .rst(rst), .width(width), .height(height),
        .num_vertical_phases(num_vertical_phases), .num_horizontal_phases(num_horizontal_phases),
        .start_read(start_read), .abort(abort),
        .vertical_phases(b_v), .horizontal_phases(b_h), .read_sample(b_rs),
        .pixel_x(b_x), .pixel_y(b_y), .busy(b_busy), .read_completed(b_rc));

    always #5 clk = ~clk;

    typedef struct {
        logic        done;
        int          cyc;
        logic [15:0] x;
        logic [15:0] y;
    } ev_t;

    ev_t qa[$];
    ev_t qb[$];
    ev_t ea, eb;
    int  cyc = 0;
    int  compared = 0;
    int  mismatched = 0;
    int  base;
    bit  bad_phase;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_ev(input int inst, input logic done, input int c, input int x, input int y);
        ev_t e;
        e.done = done; e.cyc = c; e.x = 16'(x); e.y = 16'(y);
        if (inst == 0) qa.push_back(e); else qb.push_back(e);
    endtask

    // Expected events of one frame, keeping only those at cycle <= cutoff.
    task automatic push_frame(input int inst, input int b, input int w, input int h,
                              input int n, input int m, input int cutoff);
        int v, hh, pix, row;
        v  = (inst == 0) ? 2 : 4;
        hh = (inst == 0) ? 1 : 2;
        if (n == 0) n = 1;
        if (m == 0) m = 1;
        pix = m * hh + 1;
        row = n * v + w * pix;
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                if (y * row + n * v + x * pix + m * hh + 1 <= cutoff)
                    push_ev(inst, 1'b0, b + y * row + n * v + x * pix + m * hh + 1, x, y);
        if (w == 0 || h == 0) begin
            if (cutoff >= 1) push_ev(inst, 1'b1, b + 1, 0, 0);
        end else if (h * row + 1 <= cutoff) begin
            push_ev(inst, 1'b1, b + h * row + 1, 0, 0);
        end
    endtask

    // Drive start at a negedge; base is that cycle, so cycle k is seen at cyc == base+k.
    task automatic start_frame(input int w, input int h, input int n, input int m, input int cutoff);
        @(negedge clk);
        width = 16'(w); height = 16'(h);
        num_vertical_phases = 4'(n); num_horizontal_phases = 3'(m);
        start_read = 1'b1;
        base = cyc;
        push_frame(0, base, w, h, n, m, cutoff);
        push_frame(1, base, w, h, n, m, cutoff);
        @(negedge clk);
        start_read = 1'b0;
    endtask

    task automatic wait_cycle(input int k);
        while (cyc < base + k) @(negedge clk);
    endtask

    task automatic wait_idle(input int bound, input bit watch);
        int i;
        for (i = 0; i < bound; i++) begin
            if (watch && (a_v > 16'd1 || a_h > 8'd1 || b_v > 16'd1 || b_h > 8'd1)) bad_phase = 1'b1;
            if (!a_busy && !b_busy) break;
            @(negedge clk);
        end
        if (i == bound) chk("idle_timeout", 32'(i), 32'(0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a_outs"}, {a_v, a_h, 3'b0, a_rs, a_busy, a_rc}, 32'd0);
        chk({tag, "_b_outs"}, {b_v, b_h, 3'b0, b_rs, b_busy, b_rc}, 32'd0);
        chk({tag, "_a_xy"}, {a_x, a_y}, 32'd0);
        chk({tag, "_b_xy"}, {b_x, b_y}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (a_rs || a_rc) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_event", {30'd0, a_rs, a_rc}, 32'd0);
            end else begin
                ea = qa.pop_front();
                chk("a_kind", 32'(a_rc), 32'(ea.done));
                chk("a_cycle", 32'(cyc), 32'(ea.cyc));
                if (!ea.done) chk("a_xy", {a_x, a_y}, {ea.x, ea.y});
            end
        end
        if (b_rs || b_rc) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_event", {30'd0, b_rs, b_rc}, 32'd0);
            end else begin
                eb = qb.pop_front();
                chk("b_kind", 32'(b_rc), 32'(eb.done));
                chk("b_cycle", 32'(cyc), 32'(eb.cyc));
                if (!eb.done) chk("b_xy", {b_x, b_y}, {eb.x, eb.y});
            end
        end
    end

    logic [15:0] vtab [14];
    logic [7:0]  htab [14];

    initial begin
        vtab = '{16'h1, 16'h1, 16'h2, 16'h2, 16'h4, 16'h4, 16'h0,
                 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        htab = '{8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h1,
                 8'h2, 8'h0, 8'h1, 8'h2, 8'h0, 8'h0, 8'h0};
        rst = 1'b1; start_read = 1'b0; abort = 1'b0;
        width = '0; height = '0; num_vertical_phases = '0; num_horizontal_phases = '0;
        bad_phase = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Basic frame: per-cycle phase table on the V=2,H=1 instance.
        start_frame(2, 1, 3, 2, 1000);
        for (int k = 1; k <= 14; k++) begin
            wait_cycle(k);
            chk("basic_vphase", 32'(a_v), 32'(vtab[k-1]));
            chk("basic_hphase", 32'(a_h), 32'(htab[k-1]));
        end
        chk("basic_busy14", 32'(a_busy), 32'd0);
        wait_idle(200, 1'b0);

        // Multi-row frame, with a second start pulse mid-frame that must be ignored.
        start_frame(3, 4, 2, 3, 1000);
        wait_cycle(20);
        width = 16'd7; height = 16'd9; start_read = 1'b1;
        @(negedge clk);
        start_read = 1'b0;
        wait_idle(300, 1'b0);
        chk("multirow_queues_drained", 32'(qa.size() + qb.size()), 32'd0);

        // Zero size completes on cycle 1 with no phase activity.
        start_frame(0, 5, 2, 2, 1000);
        wait_cycle(1);
        chk("zero_size_phases", {a_v, a_h, b_h}, 32'd0);
        wait_idle(20, 1'b0);

        // Zero phase counts act as one phase each.
        bad_phase = 1'b0;
        start_frame(2, 2, 0, 0, 1000);
        wait_idle(200, 1'b1);
        chk("zero_phase_onehot0", 32'(bad_phase), 32'd0);

        // Abort during the second HSHIFT of instance A (cycle 10).
        start_frame(2, 1, 3, 2, 10);
        wait_cycle(10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_all_zero("abort");
        repeat (30) @(negedge clk);
        chk("abort_queues_drained", 32'(qa.size() + qb.size()), 32'd0);

        // Start with abort in IDLE: start wins, full frame follows.
        @(negedge clk);
        abort = 1'b1;
        start_frame(2, 1, 3, 2, 1000);
        abort = 1'b0;
        wait_idle(200, 1'b0);

        // Reset during VSHIFT.
        start_frame(2, 2, 2, 2, 2);
        wait_cycle(2);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("rst_mid");
        rst = 1'b0;
        repeat (40) @(negedge clk);

        chk("final_qa_empty", 32'(qa.size()), 32'd0);
        chk("final_qb_empty", 32'(qb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ccd_readout_sequencer.md
Name: ccd_readout_sequencer

Overview:
Generates the CCD readout clocking for one full frame: a row transfer on the vertical phases, then a horizontal shift of every pixel in that row, with a one-cycle sample strobe per pixel. It sits between the exposure/readout command logic and the CCD clock drivers. It owns the vertical_phases, horizontal_phases and read_sample timing, and reports frame completion.

Parameters:
V_PHASE_CYCLES, 4, clocks each vertical phase is held (1..65535)
H_PHASE_CYCLES, 2, clocks each horizontal phase is held (1..65535)

Ports:
clk  input  1  system clock; all logic rising-edge
rst  input  1  synchronous, active-high reset
width  input  16  pixels per row; latched on accepted start
height  input  16  rows per frame; latched on accepted start
num_vertical_phases  input  4  vertical phase count N; latched on start; 0 treated as 1
num_horizontal_phases  input  3  horizontal phase count M; latched on start; 0 treated as 1
start_read  input  1  single-cycle request to read one frame
abort  input  1  terminate the readout in progress
vertical_phases  output  16  one-hot vertical clock; all zero when not in VSHIFT
horizontal_phases  output  8  one-hot horizontal clock; all zero when not in HSHIFT
read_sample  output  1  one-cycle strobe; pixel valid at output node
pixel_x  output  16  column index of current pixel, valid with read_sample
pixel_y  output  16  row index of current pixel, valid with read_sample
busy  output  1  high in every state except IDLE
read_completed  output  1  one-cycle pulse at end of frame

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset, sampled at a clock edge: state IDLE. All outputs 0. All counters 0. Reset overrides start_read and abort. Reset mid-frame ends the frame with no read_completed.
- States: IDLE, VSHIFT, HSHIFT, SAMPLE, DONE.
- IDLE:
  - start_read=1 latches width, height, N and M, clears the row/column/phase/dwell counters, and moves to VSHIFT next cycle.
  - If the latched width=0 or height=0, move to DONE instead.
  - start_read is ignored in every state other than IDLE.
- VSHIFT:
  - vertical_phases = 1 << vphase, for vphase = 0..N-1.
  - Each phase is held V_PHASE_CYCLES clocks.
  - After phase N-1 completes, go to HSHIFT with col=0 and hphase=0.
- HSHIFT:
  - horizontal_phases = 1 << hphase, for hphase = 0..M-1.
  - Each phase is held H_PHASE_CYCLES clocks.
  - After phase M-1 completes, go to SAMPLE.
- SAMPLE: exactly one cycle. read_sample=1, pixel_x=col, pixel_y=row, both phase outputs zero. Next state:
  - col < width-1: col+1, back to HSHIFT with hphase=0.
  - col = width-1 and row < height-1: row+1, back to VSHIFT with vphase=0.
  - col = width-1 and row = height-1: go to DONE.
- DONE: one cycle with read_completed=1, then IDLE.
- busy = 1 in VSHIFT, HSHIFT, SAMPLE and DONE.
- pixel_x and pixel_y hold their last value outside SAMPLE; they are only meaningful while read_sample=1.
- Timing: cycles per pixel = M*H_PHASE_CYCLES + 1; cycles per row = N*V_PHASE_CYCLES + width*(M*H_PHASE_CYCLES + 1).
  - read_completed is asserted at cycle height*row_cycles + 1, counting the cycle after the start edge as cycle 1.
- Arithmetic: the dwell counter is 16 bits and compares against PARAM-1. Row and column counters are 16 bits; width/height 65535 is legal, with no wrap inside a frame.
- abort=1 in any non-IDLE state: next cycle IDLE, all outputs 0, no read_completed. abort has priority over all transitions. abort in IDLE has no effect.
- start_read and abort high in the same cycle in IDLE: start is accepted. The abort is ignored because the block is in IDLE.
- Changing width, height or the phase inputs during a frame has no effect; the latched copies are used.

Test Plan:
- Basic frame: params V=2, H=1. Inputs width=2, height=1, N=3, M=2. Pulse start_read.
  - Required: vertical_phases 0x1,0x1,0x2,0x2,0x4,0x4 on cycles 1-6.
  - horizontal_phases 0x1,0x2 on cycles 7-8; read_sample on cycle 9 (x=0,y=0).
  - horizontal 0x1,0x2 on cycles 10-11; read_sample on cycle 12 (x=1,y=0).
  - read_completed on cycle 13; busy low on cycle 14.
- Multi-row frame: width=3, height=4, N=2, M=3, default params.
  - Required: exactly 12 read_sample pulses, in (x,y) order (0,0)..(2,0),(0,1)..(2,3).
  - Required: read_completed at cycle 4*(8+3*7)+1 = 117.
- Zero size: width=0, height=5.
  - Required: read_completed on cycle 1, no phase activity, no read_sample.
- Zero phases: N=0, M=0.
  - Required: behaves as N=1, M=1; vertical_phases only 0x1, horizontal_phases only 0x1.
- Abort mid-frame: abort asserted during the second HSHIFT.
  - Required: next cycle busy=0 and all outputs 0; read_completed never pulses.
  - Required: a new start_read then produces a full, correct frame.
- Reset and ignored start: rst asserted during VSHIFT forces IDLE with all outputs zero on the next cycle. Separately, start_read pulsed while busy is ignored: the sample count and completion cycle are unchanged.
